// File: rtl/eth_pcs_rx_block_sync.sv
// 10GBASE-R receive block lock: watches sync headers, declares/withdraws
// lock, requests gearbox slips and gates data towards the descrambler.
module eth_pcs_rx_block_sync #(
  parameter int W_DATA         = 32,
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clk_en,
  input  logic              i_hdr_valid,
  input  logic [1:0]        i_sh,
  input  logic [W_DATA-1:0] i_data,
  output logic [W_DATA-1:0] o_data,
  output logic              o_data_valid,
  output logic [1:0]        o_sh,
  output logic              o_block_lock,
  output logic              o_slip,
  output logic              o_hdr_err,
  output logic [7:0]        o_slip_cnt
);

  localparam int SW_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  typedef enum logic [1:0] {
    LOCK_INIT,
    RESET_CNT,
    TEST_SH,
    WAIT_SLIP
  } state_e;

  state_e            state_q, state_d;
  logic [6:0]        sh_cnt_q, sh_cnt_d;
  logic [4:0]        inv_cnt_q, inv_cnt_d;
  logic [SW_W-1:0]   sw_cnt_q, sw_cnt_d;
  logic              lock_q, lock_d;
  logic              slip_q, slip_d;
  logic              hdr_err_q, hdr_err_d;
  logic [7:0]        slip_cnt_q, slip_cnt_d;
  logic [W_DATA-1:0] data_q, data_d;
  logic [1:0]        sh_q, sh_d;
  logic              dv_q, dv_d;

  logic       hdr_evt;
  logic       sh_bad;
  logic [6:0] sh_cnt_inc;
  logic [4:0] inv_cnt_inc;
  logic       win_end;
  logic       lose;
  logic       slip_evt;
  logic       sw_last;

  // 2'b00 and 2'b11 are the two illegal sync headers
  assign hdr_evt     = i_clk_en & i_hdr_valid;
  assign sh_bad      = ~(i_sh[1] ^ i_sh[0]);
  assign sh_cnt_inc  = sh_cnt_q + 7'd1;
  assign inv_cnt_inc = inv_cnt_q + {4'd0, sh_bad};
  assign win_end     = (sh_cnt_inc == 7'(SH_CNT_MAX));
  assign lose        = lock_q ? (inv_cnt_inc == 5'(SH_INVALID_MAX))
                              : sh_bad;
  assign slip_evt    = hdr_evt & (state_q == TEST_SH) & lose;
  assign sw_last     = (sw_cnt_q == SW_W'(SLIP_WAIT - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= LOCK_INIT;
      sh_cnt_q   <= '0;
      inv_cnt_q  <= '0;
      sw_cnt_q   <= '0;
      lock_q     <= 1'b0;
      slip_q     <= 1'b0;
      hdr_err_q  <= 1'b0;
      slip_cnt_q <= '0;
      data_q     <= '0;
      sh_q       <= '0;
      dv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      sw_cnt_q   <= sw_cnt_d;
      lock_q     <= lock_d;
      slip_q     <= slip_d;
      hdr_err_q  <= hdr_err_d;
      slip_cnt_q <= slip_cnt_d;
      data_q     <= data_d;
      sh_q       <= sh_d;
      dv_q       <= dv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_clk_en) begin
      unique case (state_q)
        LOCK_INIT: state_d = RESET_CNT;
        RESET_CNT: state_d = TEST_SH;
        TEST_SH: begin
          if (slip_evt)
            state_d = WAIT_SLIP;
          else if (hdr_evt && win_end)
            state_d = RESET_CNT;
        end
        WAIT_SLIP: if (sw_last) state_d = RESET_CNT;
        default:   state_d = LOCK_INIT;
      endcase
    end
  end

  always_comb begin
    sh_cnt_d   = sh_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    sw_cnt_d   = sw_cnt_q;
    lock_d     = lock_q;
    slip_d     = 1'b0;
    hdr_err_d  = 1'b0;
    slip_cnt_d = slip_cnt_q;
    data_d     = i_clk_en ? i_data : data_q;
    sh_d       = i_clk_en ? i_sh : sh_q;
    dv_d       = i_clk_en & lock_q;
    if (i_clk_en) begin
      unique case (state_q)
        RESET_CNT: begin
          sh_cnt_d  = '0;
          inv_cnt_d = '0;
        end
        TEST_SH: begin
          if (hdr_evt) begin
            sh_cnt_d  = sh_cnt_inc;
            inv_cnt_d = inv_cnt_inc;
            hdr_err_d = sh_bad;
            if (slip_evt) begin
              lock_d   = 1'b0;
              slip_d   = 1'b1;
              sw_cnt_d = '0;
              if (slip_cnt_q != 8'hFF)
                slip_cnt_d = slip_cnt_q + 8'd1;
            end else if (win_end) begin
              lock_d = 1'b1;
            end
          end
        end
        WAIT_SLIP: begin
          sw_cnt_d = sw_cnt_q + SW_W'(1);
          lock_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = dv_q;
  assign o_sh         = sh_q;
  assign o_block_lock = lock_q;
  assign o_slip       = slip_q;
  assign o_hdr_err    = hdr_err_q;
  assign o_slip_cnt   = slip_cnt_q;

endmodule

// File: tb/tb_eth_pcs_rx_block_sync.sv
// Directed bench for eth_pcs_rx_block_sync: vector table for acquisition
// plus hand sequences for tolerance, enable gating, async reset, saturation.
module tb_eth_pcs_rx_block_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        hv = 1'b0;
  logic [1:0]  sh = 2'b00;
  logic [31:0] din = '0;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic [1:0]  o_sh;
  logic        o_block_lock;
  logic        o_slip;
  logic        o_hdr_err;
  logic [7:0]  o_slip_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eth_pcs_rx_block_sync dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_clk_en     (en),
    .i_hdr_valid  (hv),
    .i_sh         (sh),
    .i_data       (din),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_sh         (o_sh),
    .o_block_lock (o_block_lock),
    .o_slip       (o_slip),
    .o_hdr_err    (o_hdr_err),
    .o_slip_cnt   (o_slip_cnt)
  );

  typedef struct {
    logic       en;
    logic       hv;
    logic [1:0] sh;
    logic       lock;
    logic       err;
    logic       slip;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  logic h_lock, h_err, h_slip, t_slip, t_lock;
  int   gate_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic h, input logic [1:0] s,
                     input logic l, input logic er, input logic sl,
                     input logic [7:0] c);
    vec_t v;
    v.en = e; v.hv = h; v.sh = s;
    v.lock = l; v.err = er; v.slip = sl; v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic cyc(input logic e, input logic h, input logic [1:0] s);
    @(negedge clk);
    en  = e;
    hv  = h;
    sh  = s;
    din = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    cyc(1'b0, 1'b1, 2'b00);
    if (o_hdr_err || o_slip || o_data_valid) gate_bad++;
  endtask

  task automatic blk(input logic [1:0] s, input bit gated);
    cyc(1'b1, 1'b1, s);
    h_lock = o_block_lock;
    h_err  = o_hdr_err;
    h_slip = o_slip;
    if (gated) gap();
    cyc(1'b1, 1'b0, 2'b01);
    t_slip = o_slip;
    t_lock = o_block_lock;
    if (gated) gap();
  endtask

  initial begin
    logic prev_lock;
    int   err_n;
    int   any_slip;
    int   min_lock;

    // Acquisition after reset, with one unlocked error on header 10
    add(1, 0, 2'b00, 0, 0, 0, 0);
    add(1, 0, 2'b00, 0, 0, 0, 0);
    for (int b = 1; b <= 9; b++) begin
      add(1, 1, 2'b01, 0, 0, 0, 0);
      add(1, 0, 2'b00, 0, 0, 0, 0);
    end
    add(1, 1, 2'b00, 0, 1, 1, 1);
    add(1, 0, 2'b00, 0, 0, 0, 1);
    for (int b = 0; b < 2; b++) begin
      add(1, 1, 2'b11, 0, 0, 0, 1);
      add(1, 0, 2'b00, 0, 0, 0, 1);
    end
    for (int b = 1; b <= 64; b++) begin
      add(1, 1, (b == 64) ? 2'b10 : 2'b01, (b == 64), 0, 0, 1);
      add(1, 0, 2'b00, (b == 64), 0, 0, 1);
    end

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en  = 1'($urandom);
      hv  = 1'($urandom);
      sh  = 2'($urandom);
      din = $urandom;
      @(posedge clk);
      #1;
      chk("rst_lock", o_block_lock, 0);
      chk("rst_slip", o_slip, 0);
      chk("rst_err", o_hdr_err, 0);
      chk("rst_cnt", o_slip_cnt, 0);
      chk("rst_dv", o_data_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_sh", o_sh, 0);
    end
    @(negedge clk);
    en = 1'b0;
    hv = 1'b0;
    rst_n = 1'b1;

    prev_lock = 1'b0;
    foreach (tbl[i]) begin
      cyc(tbl[i].en, tbl[i].hv, tbl[i].sh);
      chk($sformatf("v%0d_lock", i), o_block_lock, tbl[i].lock);
      chk($sformatf("v%0d_err", i), o_hdr_err, tbl[i].err);
      chk($sformatf("v%0d_slip", i), o_slip, tbl[i].slip);
      chk($sformatf("v%0d_cnt", i), o_slip_cnt, tbl[i].cnt);
      chk($sformatf("v%0d_dv", i), o_data_valid, tbl[i].en & prev_lock);
      if (tbl[i].en) begin
        chk($sformatf("v%0d_data", i), o_data, din);
        chk($sformatf("v%0d_sh", i), o_sh, tbl[i].sh);
      end
      prev_lock = tbl[i].lock;
    end

    // Locked window with 15 invalid headers keeps lock
    err_n = 0; any_slip = 0; min_lock = 1;
    for (int b = 1; b <= 64; b++) begin
      blk((b <= 15) ? ((b % 2) ? 2'b11 : 2'b00) : 2'b10, 1'b0);
      err_n += int'(h_err);
      any_slip += int'(h_slip) + int'(t_slip);
      if (!h_lock || !t_lock) min_lock = 0;
    end
    chk("tol15_lock", min_lock, 1);
    chk("tol15_slip", any_slip, 0);
    chk("tol15_errs", err_n, 15);
    chk("tol15_cnt", o_slip_cnt, 1);

    // Next window: the 16th invalid header drops lock
    for (int b = 1; b <= 15; b++) blk(2'b00, 1'b0);
    chk("inv15_lock", h_lock, 1);
    chk("inv15_slip", h_slip, 0);
    blk(2'b11, 1'b0);
    chk("inv16_lock", h_lock, 0);
    chk("inv16_slip", h_slip, 1);
    chk("inv16_err", h_err, 1);
    chk("inv16_cnt", o_slip_cnt, 2);
    chk("inv16_slip_1cyc", t_slip, 0);

    // Enable gating: disabled cycles carry junk headers
    gate_bad = 0;
    err_n = 0;
    for (int b = 0; b < 2; b++) begin
      blk(2'b11, 1'b1);
      err_n += int'(h_err);
    end
    chk("wait_no_err", err_n, 0);
    for (int b = 1; b <= 63; b++) blk(2'b01, 1'b1);
    chk("gate63_lock", t_lock, 0);
    blk(2'b10, 1'b1);
    chk("gate64_lock", h_lock, 1);
    chk("gate_quiet", gate_bad, 0);
    chk("gate_cnt", o_slip_cnt, 2);
    cyc(1'b1, 1'b0, 2'b01);
    chk("gate_dv", o_data_valid, 1);

    // Async reset while locked
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lock", o_block_lock, 0);
    chk("arst_cnt", o_slip_cnt, 0);
    chk("arst_dv", o_data_valid, 0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 2'b01);
    cyc(1'b1, 1'b0, 2'b01);
    blk(2'b00, 1'b0);
    chk("pre_arst2_slip", h_slip, 1);
    chk("pre_arst2_cnt", o_slip_cnt, 1);

    // Async reset inside the slip wait
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_cnt", o_slip_cnt, 0);
    chk("arst2_slip", o_slip, 0);
    chk("arst2_lock", o_block_lock, 0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 2'b01);
    cyc(1'b1, 1'b0, 2'b01);

    // Every third all-invalid block is tested and slips
    for (int b = 0; b < 762; b++) blk(2'b00, 1'b0);
    chk("sat_254", o_slip_cnt, 254);
    for (int b = 762; b < 900; b++) blk(2'b00, 1'b0);
    chk("sat_255", o_slip_cnt, 255);
    chk("sat_lock", o_block_lock, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_pcs_rx_block_sync.md
Name: eth_pcs_rx_block_sync

Overview:
Receive-side 10GBASE-R block synchronisation (block lock) for the 32-bit PCS datapath. It sits between the RX gearbox and the descrambler. It watches the 2-bit sync header delivered with each 66b block and declares or withdraws block lock. On failure it requests a one-bit-position slip from the gearbox. It also gates data forwarding to the descrambler and decoder.

Parameters:
W_DATA, 32, payload word width per clock-enabled cycle (two words per 66b block)
SH_CNT_MAX, 64, sync headers per test window
SH_INVALID_MAX, 16, invalid headers in one window that drop lock
SLIP_WAIT, 4, clock-enabled cycles ignored after a slip while the gearbox realigns

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_clk_en  in  1  datapath enable; all state advances only when high
i_hdr_valid  in  1  current word is the first half of a block; i_sh is meaningful
i_sh  in  2  sync header of the current block
i_data  in  W_DATA  payload word from gearbox
o_data  out  W_DATA  registered payload to descrambler
o_data_valid  out  1  registered; i_clk_en && o_block_lock (forwarded word)
o_sh  out  2  registered header aligned with o_data
o_block_lock  out  1  block lock status
o_slip  out  1  one-cycle slip request to gearbox
o_hdr_err  out  1  one-cycle pulse: invalid header sampled (outside SLIP_WAIT)
o_slip_cnt  out  8  saturating count of slips since reset

Behaviour:
- Interface decision: one clock i_clk; i_reset_n is asynchronous and active-low.
- Reset state: all outputs 0, state LOCK_INIT, counters 0.
- Header event: i_clk_en && i_hdr_valid. Valid header is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
- Counters: sh_cnt (7b) and sh_invalid_cnt (5b). Both update only on header events in TEST_SH.
- LOCK_INIT: next cycle go to RESET_CNT.
- RESET_CNT: clear both counters, then go to TEST_SH.
- TEST_SH, per header event:
  - sh_cnt += 1.
  - If the header is invalid: sh_invalid_cnt += 1 and pulse o_hdr_err.
- Evaluation uses the post-increment counts, decided on the same event:
  - Unlocked and the header is invalid: slip. This applies to the first invalid header, including one that is the 64th.
  - Unlocked, sh_cnt==64, all 64 headers valid: o_block_lock<=1, then RESET_CNT.
  - Locked and sh_invalid_cnt==SH_INVALID_MAX: o_block_lock<=0 and slip. This takes priority over window end.
  - Locked, sh_cnt==64, sh_invalid_cnt<16: RESET_CNT, lock held.
- Slip action:
  - o_slip=1 for exactly one i_clk cycle, registered so it appears the cycle after the event.
  - o_slip_cnt += 1, saturating at 255.
  - Enter SLIP_WAIT.
- SLIP_WAIT:
  - Count SLIP_WAIT clock-enabled cycles, then go to RESET_CNT.
  - Header events are ignored: no counting, no o_hdr_err.
  - o_block_lock stays 0.
- Latency:
  - o_block_lock rises one cycle after the 64th valid header event.
  - o_data, o_sh and o_data_valid lag the inputs by one cycle.
- When i_clk_en is low: no state or counter change; o_data_valid=0; o_slip and o_hdr_err are not asserted.
- i_hdr_valid without i_clk_en is ignored.
- Asynchronous reset asserted mid-window or mid-SLIP_WAIT: everything clears immediately, including o_block_lock and o_slip_cnt.
- On release, restart from LOCK_INIT.

Test Plan:
1. Reset: hold i_reset_n=0 with random inputs -> all outputs 0; release -> o_block_lock=0 until 64 valid headers.
2. Acquire: 63 headers of 2'b01 -> lock 0; 64th (2'b10) -> o_block_lock=1 the next cycle, o_data_valid follows i_clk_en.
3. Unlocked error: header 10 = 2'b00 -> o_hdr_err pulse, o_slip pulse 1 cycle, o_slip_cnt=1. Next SLIP_WAIT=4 enabled cycles ignore headers (inject 2'b11: no o_hdr_err). Then 64 valid headers -> lock.
4. Locked tolerance: after lock, 15 invalid in one 64-window -> lock held, no slip. Next window with 16 invalid -> lock drops and o_slip pulses the cycle after the 16th invalid header.
5. Enable gating: i_clk_en toggling 1/0 with i_hdr_valid=1 while disabled -> only enabled events counted; lock after exactly 64 enabled events.
6. Async reset mid-lock and mid-SLIP_WAIT: assert i_reset_n=0 between clock edges -> o_block_lock, o_slip_cnt, o_data_valid clear immediately. o_slip_cnt saturation: 300 forced slips -> holds 255.
